// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage access sequencer: scalar/vector requests to 32-bit bus beats
module mem_access_unit #(
    parameter int LANES  = 4,
    parameter int STRIDE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_mem_read,
    input  logic         mem_mem_write,
    input  logic         mem_vector_op,
    input  logic [127:0] mem_alu_result,
    input  logic [127:0] mem_write_data,
    output logic         mem_stall,
    output logic [127:0] mem_read_data,
    output logic         mem_read_valid,
    output logic         bus_req,
    output logic         bus_we,
    output logic [31:0]  bus_addr,
    output logic [31:0]  bus_wdata,
    input  logic         bus_ack,
    input  logic [31:0]  bus_rdata
);

    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

    logic [1:0]    state;
    logic [BW-1:0] beat;
    logic          op_write;
    logic          op_vector;
    logic [127:0]  wbuf;
    logic [127:0]  rbuf;

    logic          last_beat;
    logic [BW-1:0] beat_inc;
    logic [127:0]  rbuf_next;
    logic [127:0]  read_result;

    // Only the low word of the address operand is meaningful.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_alu_result[127:32];

    // Stall while a request waits to be accepted and for every beat in flight; DONE releases the pipeline.
    assign mem_stall = ((state == S_IDLE) && (mem_mem_read || mem_mem_write)) || (state == S_ACCESS);

    // Beat bookkeeping and the lane buffer as it will look once the current beat's data is merged.
    always_comb begin
        last_beat   = op_vector ? (beat == LAST_BEAT) : (beat == '0);
        beat_inc    = beat + 1'b1;
        rbuf_next   = rbuf;
        rbuf_next[{beat, 5'd0} +: 32] = bus_rdata;
        read_result = op_vector ? rbuf_next : {4{bus_rdata}};
    end

    // Sequencer: accept in IDLE, walk beats in ACCESS, retire in DONE.
    // Read data is published on the edge into DONE so it and its valid pulse are visible during DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            beat           <= '0;
            op_write       <= 1'b0;
            op_vector      <= 1'b0;
            wbuf           <= '0;
            rbuf           <= '0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            mem_read_data  <= '0;
            mem_read_valid <= 1'b0;
        end else begin
            mem_read_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_mem_read || mem_mem_write) begin
                        op_write  <= mem_mem_write;
                        op_vector <= mem_vector_op;
                        wbuf      <= mem_write_data;
                        beat      <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_mem_write;
                        bus_addr  <= mem_alu_result[31:0];
                        bus_wdata <= mem_write_data[31:0];
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (bus_ack) begin
                        if (!op_write) begin
                            rbuf <= rbuf_next;
                        end
                        if (last_beat) begin
                            bus_req <= 1'b0;
                            state   <= S_DONE;
                            if (!op_write) begin
                                mem_read_data  <= read_result;
                                mem_read_valid <= 1'b1;
                            end
                        end else begin
                            beat      <= beat_inc;
                            bus_addr  <= bus_addr + 32'(STRIDE);
                            bus_wdata <= wbuf[{beat_inc, 5'd0} +: 32];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int LANES  = 4;
    localparam int STRIDE = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_mem_read, mem_mem_write, mem_vector_op;
    logic [127:0] mem_alu_result, mem_write_data;
    logic         mem_stall;
    logic [127:0] mem_read_data;
    logic         mem_read_valid;
    logic         bus_req, bus_we;
    logic [31:0]  bus_addr, bus_wdata;
    logic         bus_ack;
    logic [31:0]  bus_rdata;

    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] model_rdata = '0;
    int           low_run = 0;
    int           last_gap = 0;

    mem_access_unit #(.LANES(LANES), .STRIDE(STRIDE)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_vector_op  (mem_vector_op),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_stall      (mem_stall),
        .mem_read_data  (mem_read_data),
        .mem_read_valid (mem_read_valid),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    // Length of the most recent run of bus_req=0 cycles that ended in a new beat.
    always @(negedge clk) begin
        if (bus_req) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory-stage instruction, entered and left on a falling edge in an IDLE cycle.
    // waits < 0 picks 0..3 responder wait cycles per beat at random.
    task automatic run_txn(input logic rd, input logic wr, input logic vec,
                           input logic [31:0] addr, input logic [127:0] wd,
                           input logic [127:0] rwords, input int waits);
        int n_beats;
        int w;
        int stall_cnt;
        int exp_stall;
        logic is_read;
        logic [31:0] ea;
        n_beats   = vec ? LANES : 1;
        is_read   = rd && !wr;
        stall_cnt = 0;
        exp_stall = 1;
        chk("idle_valid", mem_read_valid, 1'b0);
        chk("held_rdata", mem_read_data, model_rdata);
        mem_mem_read   = rd;
        mem_mem_write  = wr;
        mem_vector_op  = vec;
        mem_alu_result = {$urandom, $urandom, $urandom, addr};
        mem_write_data = wd;
        #1;
        chk("idle_req", bus_req, 1'b0);
        chk("idle_stall", mem_stall, 1'b1);
        if (mem_stall) stall_cnt++;
        for (int b = 0; b < n_beats; b++) begin
            w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
            exp_stall += w + 1;
            ea = addr + 32'(b * STRIDE);
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                chk("beat_req", bus_req, 1'b1);
                chk("beat_we", bus_we, wr);
                chk("beat_addr", bus_addr, ea);
                chk("beat_wdata", bus_wdata, wd[b*32 +: 32]);
                if (mem_stall) stall_cnt++;
                if (k == w) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rwords[b*32 +: 32];
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
        @(negedge clk);
        if (is_read) model_rdata = vec ? rwords : {4{rwords[31:0]}};
        chk("done_req", bus_req, 1'b0);
        chk("done_stall", mem_stall, 1'b0);
        chk("done_valid", mem_read_valid, is_read);
        chk("done_rdata", mem_read_data, model_rdata);
        chk("stall_cycles", 128'(stall_cnt), 128'(exp_stall));
        bus_ack       = 1'($urandom_range(0, 1));
        bus_rdata     = $urandom;
        mem_mem_read  = 1'b0;
        mem_mem_write = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    initial begin
        logic [127:0] rw;
        logic [31:0]  word;
        rst_n = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_vector_op = 1'b0;
        mem_alu_result = '0; mem_write_data = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #1;
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", mem_read_data, 128'h0);
        chk("rst_valid", mem_read_valid, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Scalar read, two waits, replicated result.
        run_txn(1'b1, 1'b0, 1'b0, 32'h100, 128'h0, {4{32'hDEADBEEF}}, 2);
        // Vector write, zero-wait.
        run_txn(1'b0, 1'b1, 1'b1, 32'h200, {32'h44, 32'h33, 32'h22, 32'h11}, 128'h0, 0);
        // Vector read across the address wrap, random waits.
        rw = {$urandom, $urandom, $urandom, $urandom};
        run_txn(1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, {$urandom, $urandom, $urandom, $urandom}, rw, -1);
        // Read and write together: write wins.
        run_txn(1'b1, 1'b1, 1'b0, 32'h300, {$urandom, $urandom, $urandom, 32'hCAFEF00D}, {4{32'h12345678}}, -1);
        // Two consecutive scalar loads.
        word = $urandom;
        run_txn(1'b1, 1'b0, 1'b0, 32'h400, 128'h0, {4{word}}, 0);
        word = $urandom;
        run_txn(1'b1, 1'b0, 1'b0, 32'h404, 128'h0, {4{word}}, 0);
        // DONE cycle plus the accepting IDLE cycle separate the two beats.
        chk("b2b_gap", 128'(last_gap), 128'd2);

        // Reset during the third beat of a zero-wait vector read.
        mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_vector_op = 1'b1;
        mem_alu_result = 128'h500;
        bus_ack = 1'b1; bus_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_addr", bus_addr, 32'h508);
        rst_n = 1'b0;
        #1;
        model_rdata = '0;
        chk("mid_rst_req", bus_req, 1'b0);
        chk("mid_rst_stall", mem_stall, 1'b1);
        chk("mid_rst_valid", mem_read_valid, 1'b0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        mem_mem_read = 1'b0;
        #1;
        chk("mid_rst_stall_idle", mem_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("late_ack_req", bus_req, 1'b0);
        chk("late_ack_stall", mem_stall, 1'b0);
        chk("late_ack_valid", mem_read_valid, 1'b0);
        chk("late_ack_rdata", mem_read_data, 128'h0);
        bus_ack = 1'b0;
        @(negedge clk);

        // Random mix of transactions.
        for (int t = 0; t < 30; t++) begin
            logic rd, wr, vec;
            logic [31:0] a;
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            vec = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
            run_txn(rd, wr, vec, a,
                    {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
